debounce_multi: RTL and testbench
=================================

# debounce_multi

Parametrised N-channel debouncer with input synchronisation, per-channel edge strobes and optional long-press detection. It is the successor to the single-channel button debouncer. It sits between raw front-panel or external control inputs and the control logic of the noise-cancelling datapath. Each channel is independent; all channels share one clock and one reset.

## Interface
Parameters:
- `N_CH`, 4, number of independent input channels (≥1)
- `CNT_W`, 16, width of each stability counter
- `COUNT_MAX`, 5000, consecutive differing cycles required to accept a change (1 ≤ COUNT_MAX ≤ 2^CNT_W−1)
- `SYNC_STAGES`, 2, synchroniser flops per channel (≥2)
- `HOLD_MAX`, 50000, cycles `db_out` must stay high before a long-press is flagged; used only with `DEBOUNCE_HOLD_EN` (1 ≤ HOLD_MAX ≤ 2^CNT_W−1)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_raw`  in  N_CH  raw asynchronous inputs
- `db_out`  out  N_CH  debounced levels
- `rise_pulse`  out  N_CH  one-cycle strobe when `db_out[i]` goes 0→1
- `fall_pulse`  out  N_CH  one-cycle strobe when `db_out[i]` goes 1→0
- `hold_pulse`  out  N_CH  one-cycle strobe on long-press detection
- `hold_active`  out  N_CH  long-press level, held until release

## Operation
- The following applies per channel i:
  - `in_raw[i]` passes through a `SYNC_STAGES`-deep flop chain. The last stage is `sync[i]`.
  - The counter increments on every edge where `sync[i] != db_out[i]`.
  - Any edge where `sync[i] == db_out[i]` clears the counter to 0, so bounces restart qualification.
  - On the edge where the counter equals `COUNT_MAX−1` and `sync[i]` still differs:
    - `db_out[i] <= sync[i]`;
    - the counter clears to 0;
    - `rise_pulse[i]` or `fall_pulse[i]` asserts, matching the direction, for exactly that one cycle, concurrent with the new `db_out[i]`.
- The counter never exceeds `COUNT_MAX−1` and does not wrap.
- Rise and fall pulses are mutually exclusive per channel. Different channels may pulse in the same cycle.
- `COUNT_MAX=1` is legal: `db_out` follows `sync` with one cycle of delay, and a pulse fires on every change.
- All outputs are registered; there is no combinational path from `in_raw` to any output.

## Timing
- Reset (async assert, released synchronously by the system) forces all of the following to 0: sync flops, counters, `db_out`, `rise_pulse`, `fall_pulse`, `hold_pulse`, `hold_active`, and the hold counters.
- An input held stable sets `db_out` on the (`SYNC_STAGES`+`COUNT_MAX`)-th rising edge after the change: 10 edges for SYNC_STAGES=2, COUNT_MAX=8.
- A glitch shorter than `COUNT_MAX` synchronised cycles never reaches `db_out`.
- Reset asserted mid-count aborts qualification. After release, a high input requires the full latency again and produces a `rise_pulse`.
- The input is assumed to reach `db_out` = 0 at reset. An input already high at reset therefore produces a `rise_pulse` after the full latency.

## Configuration
- Macro: `DEBOUNCE_HOLD_EN`.
- Defined:
  - Each channel has a hold counter that increments while `db_out[i]`=1 and saturates at `HOLD_MAX`.
  - On the edge where it reaches `HOLD_MAX`, `hold_pulse[i]` asserts for one cycle and `hold_active[i]` goes high.
  - `db_out[i]` falling clears the hold counter and `hold_active[i]` on the same edge as `fall_pulse[i]`.
  - The counter starts from 0 on the edge where `db_out` rises, so `hold_pulse` fires `HOLD_MAX` cycles after `rise_pulse`.
- Undefined: no hold counters are built; `hold_pulse` and `hold_active` are tied to 0. The port list is unchanged.

## Test plan
Bench parameters: N_CH=4, COUNT_MAX=8, SYNC_STAGES=2, HOLD_MAX=20.
- Clean press: `in_raw[0]` 0→1 held → `db_out[0]`=1 and a single-cycle `rise_pulse[0]` on the 10th edge; other channels stay 0.
- Bounce rejection: `in_raw[1]` high for 7 cycles, low for 1, then high → `db_out[1]` rises only 8 synchronised cycles after the last low; no pulse earlier.
- Independent channels: `in_raw[3:2]` 00→11 on the same edge → both `db_out` bits and both `rise_pulse` bits assert in the same cycle.
- Reset mid-count: assert `rst` 5 cycles after `in_raw[0]` rises → all outputs 0. After release with input held high → `rise_pulse[0]` exactly 10 edges later.
- Release: after a settled press, drop `in_raw[0]` → `fall_pulse[0]` one cycle, `db_out[0]`=0 on the 10th edge.
- Long press (`DEBOUNCE_HOLD_EN` defined): hold `in_raw[0]` high → `hold_pulse[0]` 20 cycles after `rise_pulse[0]`, `hold_active[0]` high until `fall_pulse[0]`. Without the macro, both stay 0.

Source files
------------

// File: rtl/debounce_multi.sv
// N-channel debouncer: input synchroniser, stability counter, rise/fall strobes.
// Define DEBOUNCE_HOLD_EN to build the per-channel long-press detector.
module debounce_multi #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned COUNT_MAX   = 5000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_MAX    = 50000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in_raw,
    output logic [N_CH-1:0] db_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic [N_CH-1:0] hold_pulse,
    output logic [N_CH-1:0] hold_active
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Elaboration-time guard against parameter sets the counters cannot represent.
    if ((N_CH < 1) || (COUNT_MAX < 1) || (SYNC_STAGES < 2) || (HOLD_MAX < 1) ||
        (64'(COUNT_MAX) > ((64'(1) << CNT_W) - 64'(1))) ||
        (64'(HOLD_MAX) > ((64'(1) << CNT_W) - 64'(1)))) begin : g_bad_cfg
        $error("debounce_multi: illegal parameter set");
    end

    logic [SYNC_STAGES-1:0][N_CH-1:0]  sync_q, sync_d;
    logic [N_CH-1:0][CNT_W-1:0]        cnt_q, cnt_d;
    logic [N_CH-1:0]                   db_q, db_d;
    logic [N_CH-1:0]                   rise_q, rise_d;
    logic [N_CH-1:0]                   fall_q, fall_d;
    logic [N_CH-1:0]                   sync_last;

    // Synchroniser chain: stage 0 samples the raw pins, last stage feeds the counters.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = in_raw;
        for (int s = 1; s < int'(SYNC_STAGES); s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Stability counter per channel; any agreement with the current level restarts it.
    always_comb begin
        cnt_d  = cnt_q;
        db_d   = db_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (sync_last[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]  = '0;
                db_d[i]   = sync_last[i];
                rise_d[i] = sync_last[i];
                fall_d[i] = ~sync_last[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign db_out     = db_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

`ifdef DEBOUNCE_HOLD_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] HOLD_PRE  = CNT_W'(HOLD_MAX - 1);

    logic [N_CH-1:0][CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N_CH-1:0]            hold_pulse_q, hold_pulse_d;
    logic [N_CH-1:0]            hold_act_q, hold_act_d;

    // Hold counter runs while the debounced level is high; a falling edge wins over detection.
    always_comb begin
        hold_cnt_d   = hold_cnt_q;
        hold_act_d   = hold_act_q;
        hold_pulse_d = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (!db_q[i] || fall_d[i]) begin
                hold_cnt_d[i] = '0;
                hold_act_d[i] = 1'b0;
            end else if (hold_cnt_q[i] != HOLD_LAST) begin
                hold_cnt_d[i] = hold_cnt_q[i] + CNT_ONE;
                if (hold_cnt_q[i] == HOLD_PRE) begin
                    hold_pulse_d[i] = 1'b1;
                    hold_act_d[i]   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q   <= '0;
            hold_pulse_q <= '0;
            hold_act_q   <= '0;
        end else begin
            hold_cnt_q   <= hold_cnt_d;
            hold_pulse_q <= hold_pulse_d;
            hold_act_q   <= hold_act_d;
        end
    end

    assign hold_pulse  = hold_pulse_q;
    assign hold_active = hold_act_q;
`else
    assign hold_pulse  = '0;
    assign hold_active = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: stimulus queues expected strobe events, a monitor checks them.
module tb_debounce_multi;

    localparam int unsigned N_CH        = 4;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned COUNT_MAX   = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned HOLD_MAX    = 20;
`ifdef DEBOUNCE_HOLD_EN
    localparam bit HOLD_ON = 1'b1;
`else
    localparam bit HOLD_ON = 1'b0;
`endif

    typedef struct {
        int unsigned cyc;
        logic [3:0]  rise;
        logic [3:0]  fall;
        logic [3:0]  hold;
        logic [3:0]  db;
        logic [3:0]  act;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] in_raw;
    logic [N_CH-1:0] db_out, rise_pulse, fall_pulse, hold_pulse, hold_active;

    int unsigned edge_cnt = 0;
    int          errors   = 0;
    int          checks   = 0;
    ev_t         exp_q[$];
    ev_t         mon_e;
    int unsigned t0;

    debounce_multi #(
        .N_CH(N_CH), .CNT_W(CNT_W), .COUNT_MAX(COUNT_MAX),
        .SYNC_STAGES(SYNC_STAGES), .HOLD_MAX(HOLD_MAX)
    ) dut (
        .clk(clk), .rst(rst), .in_raw(in_raw), .db_out(db_out),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .hold_pulse(hold_pulse), .hold_active(hold_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int unsigned c, input logic [3:0] r, input logic [3:0] f,
                        input logic [3:0] h, input logic [3:0] d, input logic [3:0] a);
        ev_t e;
        e.cyc = c; e.rise = r; e.fall = f; e.hold = h; e.db = d; e.act = a;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, edge_cnt, got, exp);
        end
    endtask

    // Monitor: every strobe the DUT presents must match the next queued event.
    always @(negedge clk) begin
        if (rst === 1'b0 && (rise_pulse | fall_pulse | hold_pulse) !== 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse at edge %0d: rise=%b fall=%b hold=%b",
                         edge_cnt, rise_pulse, fall_pulse, hold_pulse);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != edge_cnt) begin
                    errors++;
                    $display("FAIL pulse_time: got edge %0d expected edge %0d", edge_cnt, mon_e.cyc);
                end
                checks++;
                if ({rise_pulse, fall_pulse, hold_pulse, db_out, hold_active} !==
                    {mon_e.rise, mon_e.fall, mon_e.hold, mon_e.db, mon_e.act}) begin
                    errors++;
                    $display("FAIL pulse_value at edge %0d: got r=%b f=%b h=%b db=%b act=%b expected r=%b f=%b h=%b db=%b act=%b",
                             edge_cnt, rise_pulse, fall_pulse, hold_pulse, db_out, hold_active,
                             mon_e.rise, mon_e.fall, mon_e.hold, mon_e.db, mon_e.act);
                end
            end
        end
    end

    initial begin
        rst    = 1'b1;
        in_raw = '0;
        step(2);
        chk("reset_db", db_out, 4'b0000);
        chk("reset_rise", rise_pulse, 4'b0000);
        chk("reset_fall", fall_pulse, 4'b0000);
        chk("reset_hold", hold_pulse | hold_active, 4'b0000);
        rst = 1'b0;
        step(2);

        // Clean press on channel 0, then long press window
        t0 = edge_cnt;
        in_raw = 4'b0001;
        push(t0 + 10, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        if (HOLD_ON) push(t0 + 30, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001);
        step(9);
        chk("press_db_early", db_out, 4'b0000);
        step(1);
        chk("press_db", db_out, 4'b0001);
        step(22);
        chk("press_hold_active", hold_active, HOLD_ON ? 4'b0001 : 4'b0000);

        // Release channel 0
        t0 = edge_cnt;
        in_raw = 4'b0000;
        push(t0 + 10, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step(9);
        chk("release_db_early", db_out, 4'b0001);
        step(3);
        chk("release_db", db_out | hold_active, 4'b0000);

        // Bounce on channel 1: 7 high, 1 low, then high
        t0 = edge_cnt;
        in_raw = 4'b0010;
        step(7);
        in_raw = 4'b0000;
        step(1);
        in_raw = 4'b0010;
        push(t0 + 18, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
        if (HOLD_ON) push(t0 + 38, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010);
        step(9);
        chk("bounce_db_early", db_out, 4'b0000);
        step(1);
        chk("bounce_db", db_out, 4'b0010);
        step(22);
        t0 = edge_cnt;
        in_raw = 4'b0000;
        push(t0 + 10, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        step(12);

        // Channels 3 and 2 together
        t0 = edge_cnt;
        in_raw = 4'b1100;
        push(t0 + 10, 4'b1100, 4'b0000, 4'b0000, 4'b1100, 4'b0000);
        if (HOLD_ON) push(t0 + 30, 4'b0000, 4'b0000, 4'b1100, 4'b1100, 4'b1100);
        step(32);
        chk("pair_db", db_out, 4'b1100);
        t0 = edge_cnt;
        in_raw = 4'b0000;
        push(t0 + 10, 4'b0000, 4'b1100, 4'b0000, 4'b0000, 4'b0000);
        step(12);

        // Reset five cycles into qualification
        in_raw = 4'b0001;
        step(5);
        rst = 1'b1;
        #1;
        chk("midreset_db", db_out, 4'b0000);
        chk("midreset_pulses", rise_pulse | fall_pulse | hold_pulse | hold_active, 4'b0000);
        step(2);
        rst = 1'b0;
        t0 = edge_cnt;
        push(t0 + 10, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        if (HOLD_ON) push(t0 + 30, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001);
        step(9);
        chk("postreset_db_early", db_out, 4'b0000);
        step(1);
        chk("postreset_db", db_out, 4'b0001);
        step(22);
        t0 = edge_cnt;
        in_raw = 4'b0000;
        push(t0 + 10, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step(14);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses: got %0d events left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
